dac_sd_mixer: RTL and testbench



---
 rtl/dac_sd_mixer_if.sv | 30 +++
 rtl/dac_sd_mixer.sv | 232 +++++++++++++++++++++++
 tb/tb_dac_sd_mixer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dac_sd_mixer_if.sv
// Sample/volume inputs, enable and bitstream outputs of the DAC sigma-delta mixer.
// The mixer itself takes the slave side; whatever feeds the mixer takes the master side.
interface dac_sd_mixer_if;
    logic       ena;
    logic [7:0] dac0_in;
    logic [7:0] dac1_in;
    logic [7:0] dac2_in;
    logic [7:0] dac3_in;
    logic [5:0] vol0_in;
    logic [5:0] vol1_in;
    logic [5:0] vol2_in;
    logic [5:0] vol3_in;
    logic [3:0] dac_out;
    logic       sample_tick;
    logic       busy;

    modport master (
        output ena,
        output dac0_in, dac1_in, dac2_in, dac3_in,
        output vol0_in, vol1_in, vol2_in, vol3_in,
        input  dac_out, sample_tick, busy
    );

    modport slave (
        input  ena,
        input  dac0_in, dac1_in, dac2_in, dac3_in,
        input  vol0_in, vol1_in, vol2_in, vol3_in,
        output dac_out, sample_tick, busy
    );
endinterface

// File: rtl/dac_sd_mixer.sv
// Four-channel DAC output mixer: per sample period the 8-bit offset-binary samples
// are scaled by their 6-bit volumes on one shared shift-add multiplier, and the
// resulting 14-bit targets drive one sigma-delta modulator per channel.
// Build option: define DAC_SD_2ND_ORDER_EN to replace the first-order modulators
// with saturating second-order modulators; the sequencer and latency are unchanged.
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for sample_tick; snapshot of all inputs taken on it
// LOAD    | clear product, channel ch_q selected
// MUL     | 7 cycles, one multiplier bit per cycle, LSB first
// STORE   | pending target of ch_q written; next channel or COMMIT
// COMMIT  | all four live targets loaded from the pending registers
module dac_sd_mixer #(
    parameter int unsigned SAMPLE_DIV = 64
) (
    input logic           clk32,
    input logic           rst_n,
    dac_sd_mixer_if.slave bus_if
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_STORE,
        ST_COMMIT
    } state_t;

    localparam logic [9:0]  DIV_LAST = 10'(SAMPLE_DIV - 1);
    localparam logic [13:0] MIDSCALE = 14'd8192;

    state_t            state_q, state_d;
    logic [9:0]        div_q, div_d;
    logic [1:0]        ch_q, ch_d;
    logic [2:0]        bit_q, bit_d;
    logic [13:0]       prod_q, prod_d;
    logic [3:0][7:0]   snap_dac_q, snap_dac_d;
    logic [3:0][5:0]   snap_vol_q, snap_vol_d;
    logic [3:0][13:0]  pend_q, pend_d;
    logic [3:0][13:0]  target_q, target_d;
    logic [3:0]        dac_out_q;

    logic              tick;
    logic [7:0]        s_cur;
    logic [7:0]        m_cur;
    logic [13:0]       s_ext;
    logic [13:0]       pp;

    assign tick               = bus_if.ena && (div_q == DIV_LAST);
    assign bus_if.sample_tick = tick;
    assign bus_if.busy        = (state_q != ST_IDLE);
    assign bus_if.dac_out     = dac_out_q;

    // Sample-period divider; frozen while the sequencer is disabled.
    always_comb begin
        div_d = div_q;
        if (bus_if.ena) begin
            div_d = (div_q == DIV_LAST) ? 10'd0 : div_q + 10'd1;
        end
    end

    // Operand selection for the current channel: sample-128 is the offset-binary
    // value with its MSB flipped; volume 63 is treated as exactly unity (x64).
    always_comb begin
        s_cur = snap_dac_q[ch_q] ^ 8'h80;
        m_cur = (snap_vol_q[ch_q] == 6'd63) ? 8'd64 : {2'b00, snap_vol_q[ch_q]};
        s_ext = {{6{s_cur[7]}}, s_cur};
        pp    = s_ext << bit_q;
    end

    // Sequencer next-state and datapath next values.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        bit_d      = bit_q;
        prod_d     = prod_q;
        snap_dac_d = snap_dac_q;
        snap_vol_d = snap_vol_q;
        pend_d     = pend_q;
        target_d   = target_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    snap_dac_d = {bus_if.dac3_in, bus_if.dac2_in, bus_if.dac1_in, bus_if.dac0_in};
                    snap_vol_d = {bus_if.vol3_in, bus_if.vol2_in, bus_if.vol1_in, bus_if.vol0_in};
                    ch_d       = 2'd0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                prod_d  = 14'd0;
                bit_d   = 3'd0;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                if (m_cur[bit_q]) begin
                    prod_d = prod_q + pp;
                end
                if (bit_q == 3'd6) begin
                    state_d = ST_STORE;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            ST_STORE: begin
                pend_d[ch_q] = prod_q + MIDSCALE;
                if (ch_q == 2'd3) begin
                    state_d = ST_COMMIT;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                target_d = pend_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer, divider and target registers.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= 10'd0;
            ch_q       <= 2'd0;
            bit_q      <= 3'd0;
            prod_q     <= 14'd0;
            snap_dac_q <= '0;
            snap_vol_q <= '0;
            pend_q     <= '0;
            target_q   <= {4{MIDSCALE}};
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            ch_q       <= ch_d;
            bit_q      <= bit_d;
            prod_q     <= prod_d;
            snap_dac_q <= snap_dac_d;
            snap_vol_q <= snap_vol_d;
            pend_q     <= pend_d;
            target_q   <= target_d;
        end
    end

`ifdef DAC_SD_2ND_ORDER_EN

    logic signed [17:0] i1_q [4];
    logic signed [17:0] i2_q [4];
    logic signed [17:0] i1_d [4];
    logic signed [17:0] i2_d [4];
    logic [3:0]         dout_d;
    logic signed [19:0] fb;
    logic signed [19:0] sum1;
    logic signed [19:0] sum2;

    function automatic logic signed [17:0] sat18(input logic signed [19:0] v);
        if (v > 20'sd131071) begin
            return 18'sd131071;
        end else if (v < -20'sd131071) begin
            return -18'sd131071;
        end else begin
            return v[17:0];
        end
    endfunction

    // Second-order loop: feedback of full scale when the previous bit was 1.
    always_comb begin
        fb     = '0;
        sum1   = '0;
        sum2   = '0;
        dout_d = '0;
        for (int n = 0; n < 4; n++) begin
            fb        = dac_out_q[n] ? 20'sd16384 : 20'sd0;
            sum1      = 20'(i1_q[n]) + $signed({6'b000000, target_q[n]}) - fb;
            sum2      = 20'(i2_q[n]) + 20'(i1_q[n]) - fb;
            i1_d[n]   = sat18(sum1);
            i2_d[n]   = sat18(sum2);
            dout_d[n] = ~i2_d[n][17];
        end
    end

    // Integrator and output bit registers.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                i1_q[n] <= '0;
                i2_q[n] <= '0;
            end
            dac_out_q <= 4'b0000;
        end else begin
            for (int n = 0; n < 4; n++) begin
                i1_q[n] <= i1_d[n];
                i2_q[n] <= i2_d[n];
            end
            dac_out_q <= dout_d;
        end
    end

`else

    logic [3:0][13:0] acc_q;
    logic [3:0][14:0] acc15;

    // First-order loop: the carry out of the 14-bit phase accumulator is the bit.
    always_comb begin
        acc15 = '0;
        for (int n = 0; n < 4; n++) begin
            acc15[n] = {1'b0, acc_q[n]} + {1'b0, target_q[n]};
        end
    end

    // Accumulator and output bit registers.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            dac_out_q <= 4'b0000;
        end else begin
            for (int n = 0; n < 4; n++) begin
                acc_q[n]     <= acc15[n][13:0];
                dac_out_q[n] <= acc15[n][14];
            end
        end
    end

`endif

endmodule

// File: tb/tb_dac_sd_mixer.sv
// Directed bench for dac_sd_mixer (first-order build, SAMPLE_DIV = 64).
// Expected targets come from an arithmetic model, are queued when a sample
// period is launched and are popped when the sequencer commits.
`timescale 1ns/1ps
module tb_dac_sd_mixer;

    logic clk32 = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk32 = ~clk32;

    dac_sd_mixer_if bus_if ();

    dac_sd_mixer #(.SAMPLE_DIV(64)) dut (
        .clk32  (clk32),
        .rst_n  (rst_n),
        .bus_if (bus_if)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [13:0] exp_q [$];
    logic [7:0]  d [4];
    logic [5:0]  v [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] model_target(input logic [7:0] dv, input logic [5:0] vv);
        int s;
        int m;
        s = int'(dv) - 128;
        m = (vv == 6'd63) ? 64 : int'(vv);
        return 14'(s * m + 8192);
    endfunction

    task automatic step();
        @(posedge clk32);
        #1;
    endtask

    task automatic apply();
        bus_if.dac0_in = d[0];
        bus_if.dac1_in = d[1];
        bus_if.dac2_in = d[2];
        bus_if.dac3_in = d[3];
        bus_if.vol0_in = v[0];
        bus_if.vol1_in = v[1];
        bus_if.vol2_in = v[2];
        bus_if.vol3_in = v[3];
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        while (!bus_if.sample_tick && n < budget) begin
            step();
            n++;
        end
        check("tick_seen", 32'(bus_if.sample_tick), 32'd1);
    endtask

    task automatic push_expected();
        for (int ch = 0; ch < 4; ch++) begin
            exp_q.push_back(model_target(d[ch], v[ch]));
        end
    endtask

    // Called in the cycle after sample_tick; n counts cycles since the tick cycle.
    task automatic wait_commit(input int start, input string tag);
        int n;
        n = start;
        while (bus_if.busy && n < 80) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd38);
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("%s_target%0d", tag, ch), 32'(dut.target_q[ch]), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        int n;
        int alt0, ones1, ones2, ones3, alt2;
        logic p0, p2;

        bus_if.ena = 1'b1;
        d[0] = 8'h80; v[0] = 6'd63;
        d[1] = 8'hFF; v[1] = 6'd63;
        d[2] = 8'h00; v[2] = 6'd63;
        d[3] = 8'hC0; v[3] = 6'd32;
        apply();

        repeat (100) step();
        check("rst_dac_out", 32'(bus_if.dac_out), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_tick", 32'(bus_if.sample_tick), 32'd0);
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("rst_target%0d", ch), 32'(dut.target_q[ch]), 32'd8192);
        end

        // Period 1: midscale, full scale, zero and 0xC0 at half volume.
        rst_n = 1'b1;
        wait_tick(200, n);
        check("first_tick_cycle", 32'(n), 32'd63);
        push_expected();
        step();
        check("tick_one_cycle", 32'(bus_if.sample_tick), 32'd0);
        check("busy_rise", 32'(bus_if.busy), 32'd1);
        d[3] = 8'h00; v[3] = 6'd5;
        apply();
        repeat (35) step();
        check("tgt3_before_commit", 32'(dut.target_q[3]), 32'd8192);
        step();
        check("busy_in_commit", 32'(bus_if.busy), 32'd1);
        wait_commit(37, "p1");

        bus_if.ena = 1'b0;
        repeat (2) step();
        alt0 = 0; ones1 = 0; ones2 = 0; ones3 = 0;
        p0 = bus_if.dac_out[0];
        for (int i = 0; i < 1024; i++) begin
            step();
            if (bus_if.dac_out[0] != p0) alt0++;
            p0 = bus_if.dac_out[0];
            if (bus_if.dac_out[1]) ones1++;
            if (bus_if.dac_out[2]) ones2++;
            if (bus_if.dac_out[3]) ones3++;
        end
        check("ch0_toggles", 32'(alt0), 32'd1024);
        check("ch1_ones", 32'(ones1), 32'd1020);
        check("ch2_ones", 32'(ones2), 32'd0);
        check("ch3_ones", 32'(ones3), 32'd640);

        // Period 2: volume zero on two channels, near-minimum sample at vol 62.
        d[0] = 8'h01; v[0] = 6'd62;
        d[1] = 8'h37; v[1] = 6'd0;
        v[2] = 6'd0;
        apply();
        bus_if.ena = 1'b1;
        wait_tick(100, n);
        push_expected();
        step();
        wait_commit(1, "p2");

        bus_if.ena = 1'b0;
        repeat (2) step();
        alt2 = 0;
        p2 = bus_if.dac_out[2];
        for (int i = 0; i < 64; i++) begin
            step();
            if (bus_if.dac_out[2] != p2) alt2++;
            p2 = bus_if.dac_out[2];
        end
        check("ch2_mute_toggles", 32'(alt2), 32'd64);

        // Period 3: reset asserted while the multiplier is running.
        d[0] = 8'h00; v[0] = 6'd63;
        d[1] = 8'hFF; v[1] = 6'd63;
        apply();
        bus_if.ena = 1'b1;
        wait_tick(100, n);
        push_expected();
        repeat (5) step();
        check("busy_mid_mul", 32'(bus_if.busy), 32'd1);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_dac_out", 32'(bus_if.dac_out), 32'd0);
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("midrst_target%0d", ch), 32'(dut.target_q[ch]), 32'd8192);
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (50) step();
        check("post_rst_busy", 32'(bus_if.busy), 32'd0);
        check("post_rst_target0", 32'(dut.target_q[0]), 32'd8192);
        check("post_rst_target1", 32'(dut.target_q[1]), 32'd8192);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
